// File: rtl/sdram_mem_tester.sv
// Memory-test sequencer: writes an address-derived pattern over [BEGIN_ADDR, END_ADDR], reads it
// back and compares, then repeats with the inverted pattern. Reports pass/fail and first bad address.
module sdram_mem_tester #(
    parameter int unsigned            ADDR_WIDTH = 24,
    parameter int unsigned            DATA_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0]  BEGIN_ADDR = '0,
    parameter logic [ADDR_WIDTH-1:0]  END_ADDR   = {ADDR_WIDTH{1'b1}}
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  start_i,
    output logic                  wr_o,
    output logic                  rd_o,
    output logic [ADDR_WIDTH-1:0] addr_o,
    output logic [DATA_WIDTH-1:0] data_o,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  done_i,
    output logic                  busy_o,
    output logic                  pass_o,
    output logic                  fail_o,
    output logic [ADDR_WIDTH-1:0] err_addr_o,
    output logic [7:0]            progress_o
);

    typedef enum logic [2:0] {
        StIdle,
        StWrite,
        StWrGap,
        StRead,
        StRdGap,
        StPass,
        StFail
    } state_e;

    state_e                r_state, w_state_d;
    logic                  r_inv, w_inv_d;
    logic [ADDR_WIDTH-1:0] r_addr, w_addr_d;
    logic [ADDR_WIDTH-1:0] r_err, w_err_d;
    logic [DATA_WIDTH-1:0] r_data, w_data_d;
    logic                  r_wr, w_wr_d;
    logic                  r_rd, w_rd_d;
    logic                  r_busy, w_busy_d;
    logic                  r_pass, w_pass_d;
    logic                  r_fail, w_fail_d;
    logic [7:0]            r_progress, w_progress_d;

    logic [ADDR_WIDTH-1:0] w_addr_inc;
    logic                  w_last;
    logic [DATA_WIDTH-1:0] w_expect;
    logic                  w_match;

    function automatic logic [DATA_WIDTH-1:0] pattern(input logic [DATA_WIDTH-1:0] a,
                                                     input logic inv);
        pattern = inv ? ~a : a;
    endfunction

    assign w_addr_inc = r_addr + ADDR_WIDTH'(1);
    assign w_last     = (r_addr == END_ADDR);
    assign w_expect   = pattern(r_addr[DATA_WIDTH-1:0], r_inv);
    assign w_match    = (data_i == w_expect);

    always_comb begin
        w_state_d = r_state;
        w_inv_d   = r_inv;
        w_addr_d  = r_addr;
        w_err_d   = r_err;

        unique case (r_state)
            StIdle, StPass, StFail: begin
                if (start_i) begin
                    w_state_d = StWrite;
                    w_addr_d  = BEGIN_ADDR;
                    w_inv_d   = 1'b0;
                    w_err_d   = '0;
                end
            end
            StWrite: begin
                if (done_i) begin
                    w_state_d = StWrGap;
                end
            end
            StWrGap: begin
                if (w_last) begin
                    w_addr_d  = BEGIN_ADDR;
                    w_state_d = StRead;
                end else begin
                    w_addr_d  = w_addr_inc;
                    w_state_d = StWrite;
                end
            end
            StRead: begin
                // Compare on the done edge so a mismatch lands in FAIL with no extra cycle.
                if (done_i) begin
                    if (w_match) begin
                        w_state_d = StRdGap;
                    end else begin
                        w_err_d   = r_addr;
                        w_state_d = StFail;
                    end
                end
            end
            StRdGap: begin
                if (w_last) begin
                    if (!r_inv) begin
                        w_inv_d   = 1'b1;
                        w_addr_d  = BEGIN_ADDR;
                        w_state_d = StWrite;
                    end else begin
                        w_state_d = StPass;
                    end
                end else begin
                    w_addr_d  = w_addr_inc;
                    w_state_d = StRead;
                end
            end
            default: begin
                w_state_d = StIdle;
            end
        endcase

        // Outputs are registered from the next state so requests appear on the entry edge.
        w_wr_d       = (w_state_d == StWrite);
        w_rd_d       = (w_state_d == StRead);
        w_busy_d     = (w_state_d == StWrite) || (w_state_d == StWrGap) ||
                       (w_state_d == StRead)  || (w_state_d == StRdGap);
        w_pass_d     = (w_state_d == StPass);
        w_fail_d     = (w_state_d == StFail);
        w_data_d     = pattern(w_addr_d[DATA_WIDTH-1:0], w_inv_d);
        w_progress_d = w_addr_d[ADDR_WIDTH-1 -: 8];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state    <= StIdle;
            r_inv      <= 1'b0;
            r_addr     <= '0;
            r_err      <= '0;
            r_data     <= '0;
            r_wr       <= 1'b0;
            r_rd       <= 1'b0;
            r_busy     <= 1'b0;
            r_pass     <= 1'b0;
            r_fail     <= 1'b0;
            r_progress <= '0;
        end else begin
            r_state    <= w_state_d;
            r_inv      <= w_inv_d;
            r_addr     <= w_addr_d;
            r_err      <= w_err_d;
            r_data     <= w_data_d;
            r_wr       <= w_wr_d;
            r_rd       <= w_rd_d;
            r_busy     <= w_busy_d;
            r_pass     <= w_pass_d;
            r_fail     <= w_fail_d;
            r_progress <= w_progress_d;
        end
    end

    assign wr_o       = r_wr;
    assign rd_o       = r_rd;
    assign addr_o     = r_addr;
    assign data_o     = r_data;
    assign busy_o     = r_busy;
    assign pass_o     = r_pass;
    assign fail_o     = r_fail;
    assign err_addr_o = r_err;
    assign progress_o = r_progress;

endmodule

// File: doc/sdram_mem_tester.md
# sdram_mem_tester

Memory-test sequencer that sits directly upstream of the SDRAM controller's host-side port in the SDRAM test design. It writes an address-derived pattern over a configurable address range, reads every location back, compares each word and reports pass/fail status plus the first failing address. Its outputs drive the status LEDs and the 8-digit LED display path; its start input comes from the debounced pushbutton.

## Interface

- ADDR_WIDTH, 24, host address width
- DATA_WIDTH, 16, host data width (≤ ADDR_WIDTH)
- BEGIN_ADDR, 0, first address tested
- END_ADDR, 2**ADDR_WIDTH-1, last address tested (≥ BEGIN_ADDR)

Ports:

- clk_i  in  1  sole clock, same domain as the SDRAM controller host side
- rst_i  in  1  reset, synchronous, active-high
- start_i  in  1  level; starts a run when sampled high in IDLE, PASS or FAIL
- wr_o  out  1  write request to controller
- rd_o  out  1  read request to controller
- addr_o  out  ADDR_WIDTH  host address
- data_o  out  DATA_WIDTH  write data
- data_i  in  DATA_WIDTH  read data, valid when done_i is high during a read
- done_i  in  1  one-cycle completion strobe from controller
- busy_o  out  1  high while a run is in progress
- pass_o  out  1  high in PASS
- fail_o  out  1  high in FAIL
- err_addr_o  out  ADDR_WIDTH  address of first mismatch, 0 when no failure is recorded
- progress_o  out  8  addr_o[ADDR_WIDTH-1 -: 8] for the LED display

## Operation

- Pattern: pat(a) = a[DATA_WIDTH-1:0]. Pass 0 writes and reads pat(a); pass 1 writes and reads ~pat(a).
- States: IDLE, WRITE, WR_GAP, READ, RD_GAP, PASS, FAIL.
- IDLE/PASS/FAIL with start_i=1 → WRITE. On entry: addr_o=BEGIN_ADDR, pass bit=0, err_addr_o=0.
- WRITE: wr_o=1, addr_o and data_o held stable. On done_i → WR_GAP.
- WR_GAP: one cycle, wr_o=0. If addr_o==END_ADDR, set addr_o=BEGIN_ADDR and go to READ. Otherwise increment addr_o and go to WRITE.
- READ: rd_o=1, addr_o stable. On done_i, capture the comparison data_i vs expected and go to RD_GAP.
  - On mismatch: err_addr_o=addr_o, go to FAIL, stop.
- RD_GAP: one cycle, rd_o=0.
  - If addr_o==END_ADDR and pass bit=0: pass bit=1, addr_o=BEGIN_ADDR, go to WRITE.
  - If addr_o==END_ADDR and pass bit=1: go to PASS.
  - Otherwise increment addr_o and go to READ.
- busy_o=1 in WRITE, WR_GAP, READ and RD_GAP.
- PASS and FAIL hold their state, addr_o and err_addr_o until start_i or rst_i.
- done_i is ignored in any state other than WRITE and READ.
- Only one of wr_o and rd_o is ever high. Both are never high together.
- Address arithmetic is unsigned, modulo 2**ADDR_WIDTH. END_ADDR is compared before increment, so there is no wrap past END_ADDR.

## Timing

- All outputs are registered.
- Reset values: wr_o=0, rd_o=0, addr_o=0, data_o=0, busy_o=0, pass_o=0, fail_o=0, err_addr_o=0, progress_o=0. State is IDLE.
- Request handshake: the request is asserted the cycle after entering WRITE or READ. It is held until done_i is sampled high, and deasserted on the edge after that sample.
  - There is at least one idle cycle between consecutive requests.
  - done_i in the same cycle the request first appears is accepted.
- Read compare uses data_i sampled on the same edge as done_i. Zero added latency to the FAIL decision.
- Per-word cost: 2 cycles plus controller latency.
- start_i held high in PASS or FAIL restarts immediately. A held start_i therefore loops runs back to back.
- start_i during a run is ignored.
- rst_i mid-run takes priority over everything. On that edge rd_o and wr_o drop and the state returns to IDLE. A late done_i after reset is ignored.
- BEGIN_ADDR==END_ADDR is a valid single-word test: write, read, write inverted, read inverted.

## Test plan

- Reset, then start_i=1 for one cycle. Use range 0..3 and a controller model with 3-cycle done_i latency that stores data.
  - Required: 4 writes of 0x0000 to 0x0003, then 4 reads, then 4 writes of 0xFFFF to 0xFFFC, then 4 reads.
  - Then pass_o=1, busy_o=0, fail_o=0.
- Same setup, but the model corrupts the read at address 2 on pass 0 (returns 0x0006).
  - Required: fail_o=1 on the edge after that done_i, err_addr_o=2, no further requests.
- done_i in the first request cycle (zero-latency model).
  - Required: exactly one gap cycle between requests, and rd_o/wr_o are never high together.
- Assert rst_i during READ with a done_i pending one cycle later.
  - Required: rd_o=0 and all outputs at reset values on the next edge, and the late done_i causes no transition.
- From FAIL, pulse start_i.
  - Required: err_addr_o=0, fail_o=0, busy_o=1, and writes restart at BEGIN_ADDR.
- BEGIN_ADDR=END_ADDR=0xFFFFFF.
  - Required: the pattern is 0xFFFF then 0x0000, pass_o=1 is reached, addr_o never wraps to 0, and progress_o=0xFF.
